// File: rtl/softmax_sched_pkg.sv
// Shared types and helpers for the softmax exp-input scheduler.
// Build option: SOFTMAX_SCHED_SAT_EN selects a saturating lane subtraction.
package softmax_sched_pkg;

  localparam int LANES = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SUB  = 2'd2,
    DONE = 2'd3
  } sched_state_e;

  function automatic int beats_of(input int n);
    return (n + LANES - 1) / LANES;
  endfunction

  // Operands arrive sign-extended to 64 bits; the result is clamped to the
  // signed range of a w-bit value (w <= 63).
  function automatic logic signed [63:0] sat_sub(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int unsigned        w);
    logic signed [63:0] diff;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    diff = a - b;
    hi   = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo   = -hi - 64'sd1;
    if (diff > hi) begin
      return hi;
    end else if (diff < lo) begin
      return lo;
    end
    return diff;
  endfunction

endpackage

// File: rtl/softmax_lane_sub.sv
// One lane of the shared subtractor bank: diff = max - x.
// Build option: SOFTMAX_SCHED_SAT_EN clamps to the signed range instead of wrapping.
module softmax_lane_sub #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] max_i,
  input  logic [DATA_WIDTH-1:0] x_i,
  output logic [DATA_WIDTH-1:0] diff_o
);

`ifdef SOFTMAX_SCHED_SAT_EN
  logic signed [63:0] max_ext;
  logic signed [63:0] x_ext;

  assign max_ext = 64'(signed'(max_i));
  assign x_ext   = 64'(signed'(x_i));
  assign diff_o  = DATA_WIDTH'(softmax_sched_pkg::sat_sub(max_ext, x_ext, DATA_WIDTH));
`else
  assign diff_o = max_i - x_i;
`endif

endmodule

// File: rtl/softmax_exp_input_scheduler.sv
// Two-pass scheduler: LOAD buffers a vector and tracks its signed max, SUB replays
// max - x four lanes per beat to the exp unit. Build option: SOFTMAX_SCHED_SAT_EN.
module softmax_exp_input_scheduler
  import softmax_sched_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int INTEGER    = 16,
  parameter int FRACTION   = 16,
  parameter int NUM_INPUTS = 10
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [LANES*DATA_WIDTH-1:0] in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [LANES*DATA_WIDTH-1:0] out_data,
  output logic [LANES-1:0]            out_mask,
  output logic                        out_last,
  output logic [DATA_WIDTH-1:0]       max_out,
  output logic                        busy,
  output logic                        done
);

  localparam int DW    = DATA_WIDTH;
  localparam int BEATS = beats_of(NUM_INPUTS);
  localparam int CW    = $clog2(BEATS + 1);
  localparam int IW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  if (INTEGER + FRACTION != DATA_WIDTH) begin : g_bad_format
    $error("INTEGER + FRACTION must equal DATA_WIDTH");
  end
  if (NUM_INPUTS < 1 || NUM_INPUTS > 64) begin : g_bad_length
    $error("NUM_INPUTS must be in 1..64");
  end

  sched_state_e state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [DW-1:0] max_q, max_d;

  logic [LANES*DW-1:0] buf_q [BEATS];
  logic [LANES*DW-1:0] buf_wdata;
  logic [LANES*DW-1:0] diff;
  logic [LANES-1:0]    lane_mask;
  logic [IW-1:0]       beat_idx;
  logic                in_fire;

  assign beat_idx = count_q[IW-1:0];
  assign in_fire  = in_ready & in_valid;
  assign busy     = (state_q != IDLE);
  assign max_out  = max_q;

  // Lanes whose element index falls past the vector end are padding.
  always_comb begin
    lane_mask = '0;
    for (int k = 0; k < LANES; k++) begin
      lane_mask[k] = ((int'(count_q) * LANES + k) < NUM_INPUTS);
    end
  end

  // Beat 0 lane 0 seeds the running max so all-negative vectors work.
  always_comb begin
    logic signed [DW-1:0] best;
    logic signed [DW-1:0] lane_v;
    // NOTE: blocking assignments here model a combinational chain through the
    // loop; each iteration must see the value produced by the previous one.
    best      = (count_q == '0) ? signed'(in_data[0 +: DW]) : signed'(max_q);
    lane_v    = '0;
    buf_wdata = '0;
    for (int k = 0; k < LANES; k++) begin
      lane_v = signed'(in_data[k*DW +: DW]);
      if (lane_mask[k]) begin
        buf_wdata[k*DW +: DW] = lane_v;
        if (lane_v > best) begin
          best = lane_v;
        end
      end
    end
    max_d = in_fire ? best : max_q;
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_mask  = '0;
    out_last  = 1'b0;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          count_d = '0;
        end
      end
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (count_q == LAST_BEAT) begin
            state_d = SUB;
            count_d = '0;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      SUB: begin
        out_valid = 1'b1;
        out_mask  = lane_mask;
        out_last  = (count_q == LAST_BEAT);
        if (out_ready) begin
          if (count_q == LAST_BEAT) begin
            state_d = DONE;
            count_d = '0;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      max_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      max_q   <= max_d;
    end
  end

  // NOTE: the beat buffer is deliberately cleared on reset; it is only a few
  // words, so the reset fan-out is cheap and no stale vector survives a reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < BEATS; b++) begin
        buf_q[b] <= '0;
      end
    end else if (in_fire) begin
      buf_q[beat_idx] <= buf_wdata;
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    softmax_lane_sub #(
      .DATA_WIDTH(DW)
    ) u_lane_sub (
      .max_i (max_q),
      .x_i   (buf_q[beat_idx][k*DW +: DW]),
      .diff_o(diff[k*DW +: DW])
    );
    assign out_data[k*DW +: DW] = out_mask[k] ? diff[k*DW +: DW] : '0;
  end

endmodule

// File: tb/tb_softmax_exp_input_scheduler.sv
// Self-checking bench for softmax_exp_input_scheduler against a per-element
// reference model of max - x over the whole vector.
`timescale 1ns/1ps
module tb_softmax_exp_input_scheduler;

  localparam int DW    = 32;
  localparam int N     = 10;
  localparam int L     = 4;
  localparam int BEATS = (N + L - 1) / L;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic           in_valid;
  logic           in_ready;
  logic [L*DW-1:0] in_data;
  logic           out_valid;
  logic           out_ready;
  logic [L*DW-1:0] out_data;
  logic [L-1:0]   out_mask;
  logic           out_last;
  logic [DW-1:0]  max_out;
  logic           busy;
  logic           done;

  int checks   = 0;
  int failures = 0;
  int load_lat = 0;

  logic [DW-1:0]   vec      [N];
  logic [L*DW-1:0] got_data [BEATS];
  logic [L-1:0]    got_mask [BEATS];
  logic            got_last [BEATS];

  always #5 clk = ~clk;

  softmax_exp_input_scheduler #(
    .DATA_WIDTH(DW),
    .INTEGER   (16),
    .FRACTION  (16),
    .NUM_INPUTS(N)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_mask (out_mask),
    .out_last (out_last),
    .max_out  (max_out),
    .busy     (busy),
    .done     (done)
  );

  // ---------------- reference model ----------------
  function automatic logic [DW-1:0] ref_max();
    logic signed [DW-1:0] m;
    m = vec[0];
    for (int i = 1; i < N; i++) begin
      if ($signed(vec[i]) > m) m = vec[i];
    end
    return m;
  endfunction

  function automatic logic [DW-1:0] ref_diff(input logic [DW-1:0] m, input logic [DW-1:0] x);
    longint d;
    d = longint'($signed(m)) - longint'($signed(x));
`ifdef SOFTMAX_SCHED_SAT_EN
    if (d > 64'sh7FFF_FFFF) d = 64'sh7FFF_FFFF;
`endif
    return d[DW-1:0];
  endfunction

  function automatic logic [L*DW-1:0] ref_beat(input int b);
    logic [L*DW-1:0] r;
    logic [DW-1:0]   m;
    r = '0;
    m = ref_max();
    for (int k = 0; k < L; k++) begin
      if (b * L + k < N) r[k*DW +: DW] = ref_diff(m, vec[b*L+k]);
    end
    return r;
  endfunction

  function automatic logic [L-1:0] ref_mask(input int b);
    logic [L-1:0] r;
    r = '0;
    for (int k = 0; k < L; k++) r[k] = (b * L + k < N);
    return r;
  endfunction

  // Padding lanes carry random junk that must not influence anything.
  function automatic logic [L*DW-1:0] beat_in(input int b);
    logic [L*DW-1:0] r;
    r = '0;
    for (int k = 0; k < L; k++) begin
      r[k*DW +: DW] = (b * L + k < N) ? vec[b*L+k] : $urandom();
    end
    return r;
  endfunction

  // ---------------- stimulus tasks ----------------
  task automatic load_vector(input bit gaps, input bit noisy);
    int i;
    bit go;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    load_lat = 1;
    i        = 0;
    while (i < BEATS && load_lat < 1000) begin
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        failures++;
        $display("FAIL load_handshake: in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
      end
      go       = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_valid = go;
      in_data  = beat_in(i);
      if (noisy) start = 1'($urandom_range(0, 1));
      @(negedge clk);
      load_lat++;
      if (go) i++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    in_data  = '0;
    checks++;
    if (i != BEATS) begin
      failures++;
      $display("FAIL load_timeout: accepted %0d beats, required %0d", i, BEATS);
    end
    checks++;
    if (max_out !== ref_max()) begin
      failures++;
      $display("FAIL max_out: got %h, required %h", max_out, ref_max());
    end
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL sub_entry: out_valid=%b in_ready=%b, required 1/0", out_valid, in_ready);
    end
  endtask

  // mode 0: always ready, 1: random ready, 2: five-cycle stall on beat 1
  task automatic drain(input int mode, input bit noisy, input int take);
    int  b;
    int  cyc;
    int  stall;
    bit  rdy;
    b     = 0;
    cyc   = 0;
    stall = 0;
    while (b < take && cyc < 1000) begin
      cyc++;
      checks++;
      if (out_valid !== 1'b1 || done !== 1'b0 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL sub_ctrl beat %0d: out_valid=%b done=%b in_ready=%b, required 1/0/0",
                 b, out_valid, done, in_ready);
      end
      checks++;
      if (out_data !== ref_beat(b) || out_mask !== ref_mask(b) || out_last !== (b == BEATS - 1)) begin
        failures++;
        $display("FAIL sub_beat %0d: data=%h mask=%b last=%b, required data=%h mask=%b last=%b",
                 b, out_data, out_mask, out_last, ref_beat(b), ref_mask(b), (b == BEATS - 1));
      end
      got_data[b] = out_data;
      got_mask[b] = out_mask;
      got_last[b] = out_last;
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = ($urandom_range(0, 2) != 0);
        default: begin
          if (b == 1 && stall < 5) begin
            rdy = 1'b0;
            stall++;
          end else begin
            rdy = 1'b1;
          end
        end
      endcase
      out_ready = rdy;
      if (noisy) start = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (rdy) b++;
    end
    checks++;
    if (b != take) begin
      failures++;
      $display("FAIL drain_timeout: accepted %0d beats, required %0d", b, take);
    end
    if (take == BEATS) begin
      checks++;
      if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b1) begin
        failures++;
        $display("FAIL done_pulse: done=%b out_valid=%b busy=%b, required 1/0/1", done, out_valid, busy);
      end
      out_ready = 1'b0;
      start     = noisy;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL done_single: done=%b busy=%b, required 0/0", done, busy);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL idle_after: done=%b busy=%b in_ready=%b, required 0/0/0", done, busy, in_ready);
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if ({in_ready, out_valid, out_last, busy, done} !== 5'b0 || out_mask !== '0 ||
        out_data !== '0 || max_out !== '0) begin
      failures++;
      $display("FAIL %s: ctrl=%b mask=%b data=%h max=%h, required all zero",
               tag, {in_ready, out_valid, out_last, busy, done}, out_mask, out_data, max_out);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_all_zero("reset_state");
    reset = 1'b0;
    @(negedge clk);
    check_all_zero("post_reset_idle");
  endtask

  task automatic test_basic();
    for (int i = 0; i < N; i++) vec[i] = DW'(i + 1) << 16;
    load_vector(1'b0, 1'b0);
    checks++;
    if (load_lat != BEATS + 1) begin
      failures++;
      $display("FAIL start_latency: got %0d cycles, required %0d", load_lat, BEATS + 1);
    end
    checks++;
    if (max_out !== 32'h000A_0000) begin
      failures++;
      $display("FAIL basic_max: got %h, required 000a0000", max_out);
    end
    drain(0, 1'b0, BEATS);
    checks++;
    if (got_data[0] !== {32'h0006_0000, 32'h0007_0000, 32'h0008_0000, 32'h0009_0000}) begin
      failures++;
      $display("FAIL basic_beat0: got %h, required 00060000000700000008000000090000", got_data[0]);
    end
    checks++;
    if (got_mask[2] !== 4'b0011 || got_last[2] !== 1'b1 ||
        got_data[2] !== {64'h0, 32'h0000_0000, 32'h0001_0000}) begin
      failures++;
      $display("FAIL basic_beat2: data=%h mask=%b last=%b, required data=...0000000000010000 mask=0011 last=1",
               got_data[2], got_mask[2], got_last[2]);
    end
  endtask

  task automatic test_negative();
    for (int i = 0; i < N; i++) vec[i] = -(DW'(i + 5) << 16);
    load_vector(1'b1, 1'b0);
    checks++;
    if (max_out !== 32'hFFFB_0000) begin
      failures++;
      $display("FAIL negative_max: got %h, required fffb0000", max_out);
    end
    drain(0, 1'b0, BEATS);
    checks++;
    if (got_data[0][DW-1:0] !== '0) begin
      failures++;
      $display("FAIL negative_lane0: got %h, required 00000000", got_data[0][DW-1:0]);
    end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < N; i++) vec[i] = $urandom();
    load_vector(1'b1, 1'b0);
    drain(2, 1'b0, BEATS);
  endtask

  task automatic test_ignored();
    @(negedge clk);
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1;
      in_data  = {L{32'hDEAD_BEEF}};
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
        failures++;
        $display("FAIL idle_in_valid: in_ready=%b busy=%b out_valid=%b, required 0/0/0",
                 in_ready, busy, out_valid);
      end
    end
    in_valid = 1'b0;
    for (int i = 0; i < N; i++) vec[i] = $urandom();
    load_vector(1'b1, 1'b1);
    drain(1, 1'b1, BEATS);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < N; i++) vec[i] = $urandom();
    load_vector(1'b0, 1'b0);
    drain(0, 1'b0, 2);
    reset = 1'b1;
    @(negedge clk);
    reset     = 1'b0;
    out_ready = 1'b0;
    check_all_zero("reset_mid_state");
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL reset_mid_no_done: done=%b busy=%b, required 0/0", done, busy);
      end
    end
    for (int i = 0; i < N; i++) vec[i] = $urandom();
    load_vector(1'b1, 1'b0);
    drain(1, 1'b0, BEATS);
  endtask

  task automatic test_overflow();
    logic [DW-1:0] exp_lane1;
`ifdef SOFTMAX_SCHED_SAT_EN
    exp_lane1 = 32'h7FFF_FFFF;
`else
    exp_lane1 = 32'hFFFF_0000;
`endif
    vec[0] = 32'h7FFF_0000;
    vec[1] = 32'h8000_0000;
    for (int i = 2; i < N; i++) vec[i] = {1'b1, 31'($urandom())};
    load_vector(1'b0, 1'b0);
    drain(0, 1'b0, BEATS);
    checks++;
    if (got_data[0][2*DW-1:DW] !== exp_lane1 || got_data[0][DW-1:0] !== '0) begin
      failures++;
      $display("FAIL overflow_lane: lane1=%h lane0=%h, required %h/00000000",
               got_data[0][2*DW-1:DW], got_data[0][DW-1:0], exp_lane1);
    end
  endtask

  task automatic test_back_to_back();
    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < N; i++) begin
        vec[i] = (v % 2 == 0) ? $urandom() : DW'($urandom_range(0, 15)) << 12;
      end
      load_vector(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      drain(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), BEATS);
    end
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    test_reset();
    test_basic();
    test_negative();
    test_backpressure();
    test_ignored();
    test_reset_mid();
    test_overflow();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
